// File: rtl/tl_vec_update_pkg.sv
// Shared TL math package: FSM state encoding, saturation limits, basic operators.
// Latency: pure functions, no state.
// Backpressure: not applicable.
package tl_vec_update_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLIP,
    ST_RD_Y,
    ST_RD_X,
    ST_WR,
    ST_DONE
  } state_t;

  localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_32 = 32'h8000_0000;
  localparam logic [15:0] MAX_16 = 16'h7FFF;
  localparam logic [15:0] MIN_16 = 16'h8000;

  // Clamp a signed 32-bit value into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sh0000_7FFF) return MAX_16;
    if (v < 32'shFFFF_8000) return MIN_16;
    return v[15:0];
  endfunction

  // Fractional multiply: (a*b)<<1, with the single overflow case -1 * -1 pinned to MAX_32.
  function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] prod;
    if ((a == MIN_16) && (b == MIN_16)) return MAX_32;
    prod = 32'($signed(a)) * 32'($signed(b));
    return prod <<< 1;
  endfunction

  // Saturating arithmetic left shift; 48-bit headroom covers shifts up to 15.
  function automatic logic [31:0] l_shl(input logic [31:0] v, input int unsigned sh);
    logic signed [47:0] ext;
    ext = $signed({{16{v[31]}}, v}) <<< sh;
    if (ext > 48'sh0000_7FFF_FFFF) return MAX_32;
    if (ext < 48'shFFFF_8000_0000) return MIN_32;
    return ext[31:0];
  endfunction

endpackage

// File: rtl/tl_vec_update_if.sv
// Command, status and scratch-memory signals of the vector update engine.
// Latency: wires only.
// Backpressure: none; the requester waits for done before issuing another start.
interface tl_vec_update_if #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 8
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] y_base;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] out_base;
  logic [LEN_W-1:0]  len;
  logic [15:0]       gain_in;
  logic              clip_req;
  logic [15:0]       gain_clip;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [15:0]       gain_out;
  logic              busy;
  logic              done;

  // Requester side: issues commands and returns memory read data.
  modport master (
    output start, mode, y_base, x_base, out_base, len, gain_in, clip_req, gain_clip, mem_rdata,
    input  mem_raddr, mem_waddr, mem_wdata, mem_we, gain_out, busy, done
  );

  // Engine side.
  modport slave (
    input  start, mode, y_base, x_base, out_base, len, gain_in, clip_req, gain_clip, mem_rdata,
    output mem_raddr, mem_waddr, mem_wdata, mem_we, gain_out, busy, done
  );
endinterface

// File: rtl/tl_sat_mac_dp.sv
// Combinational datapath: p = L_shl(L_mult(y, gain), SHIFT) and r = sat16(x -/+ hi(p_q)).
// Latency: 0 cycles; the caller registers p between the y and x reads.
// Backpressure: none.
module tl_sat_mac_dp
  import tl_vec_update_pkg::*;
#(
  parameter int SHIFT = 1
) (
  input  logic [15:0] y,
  input  logic [15:0] x,
  input  logic [15:0] gain,
  input  logic        mode,
  input  logic [31:0] p_q,
  output logic [31:0] p,
  output logic [15:0] r
);

  logic signed [16:0] x_ext;
  logic signed [16:0] ph_ext;
  logic signed [16:0] sum;
  logic [15:0]        unused_p_lo;

  assign p      = l_shl(l_mult(y, gain), SHIFT);
  assign x_ext  = {x[15], x};
  assign ph_ext = {p_q[31], p_q[31:16]};
  // 17 bits hold any sum/difference of two 16-bit values exactly before clamping.
  assign sum    = mode ? (x_ext + ph_ext) : (x_ext - ph_ext);
  assign r      = sat16(32'(sum));
  // Only the high half of p feeds the update (extract_h).
  assign unused_p_lo = p_q[15:0];

endmodule

// File: rtl/tl_vec_update.sv
// Target-vector update out[i] = x[i] -/+ extract_h(L_shl(L_mult(y[i], gain), SHIFT)); TL_VEC_UPDATE_CLIP_EN enables gain clipping.
// Latency: done in cycle 2+3*len after start (start = cycle 0), one element every 3 cycles.
// Backpressure: none; start is ignored while busy, memory must answer reads in exactly 1 cycle.
module tl_vec_update
  import tl_vec_update_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 8,
  parameter int SHIFT  = 1
) (
  input  logic           clock,
  input  logic           reset,
  tl_vec_update_if.slave bus
);

  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] y_base;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] out_base;
    logic [LEN_W-1:0]  len;
    logic [15:0]       gain_in;
  } cmd_t;

  state_t           state;
  state_t           state_nxt;
  cmd_t             cmd;
  logic [LEN_W-1:0] idx;
  logic [LEN_W:0]   idx_inc;
  logic             last;
  logic [31:0]      p_q;
  logic [31:0]      p_nxt;
  logic [15:0]      r;
  logic [15:0]      gain_q;
  logic [15:0]      gain_eff;
  logic             unused_rdata_hi;

  assign idx_inc = {1'b0, idx} + {{LEN_W{1'b0}}, 1'b1};
  assign last    = (idx_inc >= {1'b0, cmd.len});
  // Scratch words carry 16-bit samples in the low half.
  assign unused_rdata_hi = ^bus.mem_rdata[31:16];

`ifdef TL_VEC_UPDATE_CLIP_EN
  assign gain_eff = (bus.clip_req && ($signed(cmd.gain_in) > $signed(bus.gain_clip)))
                    ? bus.gain_clip : cmd.gain_in;
`else
  logic unused_clip;
  assign gain_eff    = cmd.gain_in;
  assign unused_clip = bus.clip_req ^ (^bus.gain_clip);
`endif

  // The same read-data bus carries y in RD_X and x in WR.
  tl_sat_mac_dp #(.SHIFT(SHIFT)) u_dp (
    .y    (bus.mem_rdata[15:0]),
    .x    (bus.mem_rdata[15:0]),
    .gain (gain_q),
    .mode (cmd.mode),
    .p_q  (p_q),
    .p    (p_nxt),
    .r    (r)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: three cycles per element, CLIP always visited so timing is build-independent.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_CLIP;
      ST_CLIP: state_nxt = (cmd.len != '0) ? ST_RD_Y : ST_DONE;
      ST_RD_Y: state_nxt = ST_RD_X;
      ST_RD_X: state_nxt = ST_WR;
      ST_WR:   state_nxt = last ? ST_DONE : ST_RD_Y;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, element index, registered product and effective gain.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd    <= '0;
      idx    <= '0;
      p_q    <= '0;
      gain_q <= '0;
    end else begin
      if ((state == ST_IDLE) && bus.start) begin
        cmd <= '{mode: bus.mode, y_base: bus.y_base, x_base: bus.x_base,
                 out_base: bus.out_base, len: bus.len, gain_in: bus.gain_in};
        idx <= '0;
      end
      if (state == ST_CLIP) gain_q <= gain_eff;
      if (state == ST_RD_X) p_q <= p_nxt;
      if (state == ST_WR)   idx <= idx_inc[LEN_W-1:0];
    end
  end

  // Memory strobes and status; forced low while reset is held so no write slips out.
  always_comb begin
    bus.mem_raddr = '0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    if (!reset) begin
      bus.busy = (state != ST_IDLE);
      unique case (state)
        ST_RD_Y: bus.mem_raddr = cmd.y_base + ADDR_W'(idx);
        ST_RD_X: bus.mem_raddr = cmd.x_base + ADDR_W'(idx);
        ST_WR: begin
          bus.mem_waddr = cmd.out_base + ADDR_W'(idx);
          bus.mem_wdata = {{16{r[15]}}, r};
          bus.mem_we    = 1'b1;
        end
        ST_DONE: bus.done = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.gain_out = gain_q;

endmodule

// File: tb/tb_tl_vec_update.sv
// Directed bench for tl_vec_update with a 1-cycle-latency scratch memory model.
// Latency: checks done/busy cycle positions relative to the start cycle.
// Backpressure: not applicable.
module tb_tl_vec_update;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  tl_vec_update_if #(.ADDR_W(12), .LEN_W(8)) bus ();

  tl_vec_update #(.ADDR_W(12), .LEN_W(8), .SHIFT(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:4095];
  logic        pre_we   = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_dat  = '0;
  int          wr_cnt   = 0;
  int          rd_cnt   = 0;
  int          n_pass   = 0;
  int          n_total  = 0;

  // Scratch memory: registered read, DUT write port plus a preload port for the bench.
  always @(posedge clock) begin
    bus.mem_rdata <= mem[bus.mem_raddr];
    if (bus.mem_we)  mem[bus.mem_waddr] <= bus.mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_dat;
  end

  // Access counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.mem_we) wr_cnt++;
    if (bus.mem_raddr != 12'h000) rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    @(negedge clock);
    pre_we   = 1'b0;
  endtask

  task automatic setup(input logic m, input logic [11:0] yb, input logic [11:0] xb,
                       input logic [11:0] ob, input logic [7:0] n, input logic [15:0] g,
                       input logic cr, input logic [15:0] gc);
    bus.mode      = m;
    bus.y_base    = yb;
    bus.x_base    = xb;
    bus.out_base  = ob;
    bus.len       = n;
    bus.gain_in   = g;
    bus.clip_req  = cr;
    bus.gain_clip = gc;
  endtask

  // Starts a command at the current negedge (cycle 0) and returns the cycle in which done is seen.
  task automatic run(input string tag, input logic m, input logic [11:0] yb, input logic [11:0] xb,
                     input logic [11:0] ob, input logic [7:0] n, input logic [15:0] g,
                     input logic cr, input logic [15:0] gc, output int done_cyc);
    int cyc;
    setup(m, yb, xb, ob, n, g, cr, gc);
    bus.start = 1'b1;
    check({tag, "_busy_c0"}, 32'(bus.busy), 32'd0);
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    done_cyc = cyc;
    @(negedge clock);
    check({tag, "_idle_after"}, 32'({bus.busy, bus.done}), 32'd0);
  endtask

  initial begin
    int dc;
    int wr0;
    int rd0;
    int cyc;

    reset = 1'b1;
    bus.start = 1'b0;
    setup(1'b0, 12'h000, 12'h000, 12'h000, 8'd0, 16'h0000, 1'b0, 16'h0000);
    repeat (3) @(negedge clock);
    check("rst_raddr", 32'(bus.mem_raddr), 32'd0);
    check("rst_waddr", 32'(bus.mem_waddr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_gain_out", 32'(bus.gain_out), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Main case: subtract, len 40, junk in the upper halves of the read words.
    for (int i = 0; i < 40; i++) begin
      poke(12'(256 + i), 32'hA5A5_0000 | 32'(i));
      poke(12'(512 + i), 32'h5A5A_0064);
    end
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    run("t1", 1'b0, 12'h100, 12'h200, 12'h300, 8'd40, 16'h4000, 1'b0, 16'h0000, dc);
    check("t1_done_cyc", dc, 32'd122);
    check("t1_writes", wr_cnt - wr0, 32'd40);
    check("t1_reads", rd_cnt - rd0, 32'd80);
    check("t1_gain_out", 32'(bus.gain_out), 32'h4000);
    for (int i = 0; i < 40; i++)
      check($sformatf("t1_out%0d", i), mem[12'(768 + i)], 32'(100 - i));

    // Gain clipping: 0x4000 against ceiling 0x3333.
    poke(12'h900, 32'h0000_0100);
    poke(12'h910, 32'h0000_0000);
    run("clip", 1'b0, 12'h900, 12'h910, 12'h920, 8'd1, 16'h4000, 1'b1, 16'h3333, dc);
    check("clip_done_cyc", dc, 32'd5);
`ifdef TL_VEC_UPDATE_CLIP_EN
    check("clip_gain_out", 32'(bus.gain_out), 32'h3333);
    check("clip_out", mem[12'h920], 32'hFFFF_FF34);
`else
    check("clip_gain_out", 32'(bus.gain_out), 32'h4000);
    check("clip_out", mem[12'h920], 32'hFFFF_FF00);
`endif

    // len 0 with a negative gain below the ceiling: no accesses, done in cycle 2.
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    run("len0", 1'b0, 12'h100, 12'h200, 12'h300, 8'd0, 16'hC000, 1'b1, 16'h3333, dc);
    check("len0_done_cyc", dc, 32'd2);
    check("len0_writes", wr_cnt - wr0, 32'd0);
    check("len0_reads", rd_cnt - rd0, 32'd0);
    check("len0_gain_out", 32'(bus.gain_out), 32'h0000_C000);

    // Saturation corners.
    poke(12'h800, 32'h0000_8000);
    poke(12'h810, 32'h0000_7FFF);
    poke(12'h811, 32'h0000_8000);
    poke(12'h812, 32'h0000_0000);
    run("satA", 1'b1, 12'h800, 12'h810, 12'h820, 8'd1, 16'h8000, 1'b0, 16'h0000, dc);
    check("satA_add_out", mem[12'h820], 32'h0000_7FFF);
    run("satB", 1'b0, 12'h800, 12'h810, 12'h820, 8'd1, 16'h8000, 1'b0, 16'h0000, dc);
    check("satB_sub_out", mem[12'h820], 32'h0000_0000);
    run("satC", 1'b1, 12'h800, 12'h811, 12'h821, 8'd1, 16'h4000, 1'b0, 16'h0000, dc);
    check("satC_neg_out", mem[12'h821], 32'hFFFF_8000);
    run("satD", 1'b0, 12'h800, 12'h812, 12'h822, 8'd1, 16'h7FFF, 1'b0, 16'h0000, dc);
    check("satD_shl_out", mem[12'h822], 32'h0000_7FFF);

    // In-place update with the y vector wrapping past the top of the address space.
    poke(12'hFFE, 32'h0000_0001);
    poke(12'hFFF, 32'h0000_0002);
    poke(12'h000, 32'h0000_0003);
    for (int i = 0; i < 3; i++) poke(12'(1024 + i), 32'h1234_FFF0);
    run("ip", 1'b0, 12'hFFE, 12'h400, 12'h400, 8'd3, 16'h4000, 1'b0, 16'h0000, dc);
    check("ip_done_cyc", dc, 32'd11);
    check("ip_out0", mem[12'h400], 32'hFFFF_FFEF);
    check("ip_out1", mem[12'h401], 32'hFFFF_FFEE);
    check("ip_out2", mem[12'h402], 32'hFFFF_FFED);

    // Reset during the write of element 5, then a clean restart.
    for (int i = 0; i < 10; i++) poke(12'(1792 + i), 32'h0000_0000);
    setup(1'b0, 12'h100, 12'h200, 12'h700, 8'd10, 16'h4000, 1'b0, 16'h0000);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 19) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_wr_pre_we", 32'(bus.mem_we), 32'd1);
    check("rst_wr_pre_waddr", 32'(bus.mem_waddr), 32'h705);
    reset = 1'b1;
    #1;
    check("rst_wr_we_gated", 32'(bus.mem_we), 32'd0);
    @(negedge clock);
    check("rst_wr_busy", 32'(bus.busy), 32'd0);
    check("rst_wr_raddr", 32'(bus.mem_raddr), 32'd0);
    check("rst_wr_gain_out", 32'(bus.gain_out), 32'd0);
    reset = 1'b0;
    check("rst_wr_elem4", mem[12'h704], 32'h0000_0060);
    check("rst_wr_elem5", mem[12'h705], 32'h0000_0000);
    @(negedge clock);
    run("rerun", 1'b0, 12'h100, 12'h200, 12'h700, 8'd10, 16'h4000, 1'b0, 16'h0000, dc);
    check("rerun_done_cyc", dc, 32'd32);
    check("rerun_elem5", mem[12'h705], 32'h0000_005F);
    check("rerun_elem9", mem[12'h709], 32'h0000_005B);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tl_vec_update.md
# tl_vec_update

Parametrised target-vector update engine for the G.729 encoder top level. Computes out[i] = x[i] ∓ extract_h(L_shl(L_mult(y[i], gain), SHIFT)) over a vector in scratch memory, with optional gain clipping and selectable add/subtract mode. It replaces fixed-length, subtract-only, xn/y1/xn2 update sequences (adaptive and fixed codebook target updates, excitation updates). Arithmetic is internal and bit-exact to ITU-T basic operators.

## Interface
- ADDR_W, 12, scratch memory address width
- LEN_W, 8, width of vector length
- SHIFT, 1, left-shift applied after L_mult (0..15)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = subtract (x − p), 1 = add (x + p); latched at start
- y_base, x_base, out_base  in  ADDR_W  vector base addresses; latched at start
- len  in  LEN_W  element count (0 allowed); latched at start
- gain_in  in  16  Q14 gain; latched at start
- clip_req  in  1  request clipping of gain_in to gain_clip
- gain_clip  in  16  clip ceiling (e.g. GPCLIP)
- mem_rdata  in  32  scratch read data, valid 1 cycle after mem_raddr
- mem_raddr  out  ADDR_W  read address
- mem_waddr  out  ADDR_W  write address
- mem_wdata  out  32  write data (sign-extended 16-bit result)
- mem_we  out  1  write strobe
- gain_out  out  16  effective gain used (after clip), held until next start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLIP, RD_Y, RD_X, WR, DONE.
- IDLE: latch inputs on start, clear index i to 0, go to CLIP. start in any other state is ignored.
- CLIP: gain = gain_clip if clip_req and signed(gain_in) > signed(gain_clip), else gain_in. Load gain_out. Go to RD_Y if len ≠ 0, else DONE.
- RD_Y: mem_raddr = y_base + i.
- RD_X: p = L_shl(L_mult(mem_rdata[15:0], gain), SHIFT), registered. mem_raddr = x_base + i.
- WR: r = sub/add(mem_rdata[15:0], p[31:16]), saturated to 16 bits. mem_waddr = out_base + i, mem_wdata = {16{r[15]}, r}, mem_we = 1. Increment i. Go to RD_Y if i+1 < len, else DONE.
- DONE: done = 1, then IDLE.
- L_mult: 0x8000 × 0x8000 saturates to 0x7FFFFFFF; otherwise (a·b)<<1.
- L_shl saturates to 0x7FFFFFFF / 0x80000000.
- Read data uses the low 16 bits; the upper 16 bits are ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- out_base may equal x_base (in-place update): element i is read before it is written, so the result is correct.
- Reset at any time: state goes to IDLE, no write issued that cycle, all registers cleared.

## Timing
- Reset values: mem_raddr, mem_waddr, mem_wdata, gain_out = 0; mem_we, busy, done = 0.
- Read/write ports are combinational from state and registers; outputs are 0 when unused.
- Start sampled at cycle 0, CLIP at cycle 1, element k occupies cycles 2+3k .. 4+3k, with the write in cycle 4+3k.
- done is high in cycle 2+3·len; busy falls in cycle 3+3·len. With len = 0, done is high in cycle 2 and no memory access occurs.
- A new start is accepted in the cycle after done (IDLE).

## Configuration
- TL_VEC_UPDATE_CLIP_EN defined: clipping logic compiled in as described.
- Undefined: gain = gain_in always, and clip_req/gain_clip are ignored (ports remain). The CLIP state is still traversed, so timing is identical.

## Structure
- The shared package holds the state encoding, the saturation constants (MAX_32 = 0x7FFFFFFF, MIN_32 = 0x80000000, MAX_16, MIN_16), and sat16/L_mult/L_shl functions reusable by other TL math blocks.
- One sub-module, tl_sat_mac_dp: a combinational datapath computing p and r from y, x, gain and mode. The FSM stays in the top module.

## Test plan
- mode=0, len=40, SHIFT=1, gain_in=0x4000, y[i]=i, x[i]=100 → out[i]=100−i for all i; done at cycle 122.
- clip_req=1, gain_in=0x4000, gain_clip=0x3333 (macro on) → gain_out=0x3333. With the macro off → gain_out=0x4000.
- y=0x8000, gain=0x8000, x=0x7FFF, mode=1 → p saturates to 0x7FFFFFFF; out=0x7FFF. With mode=0 → 0x0000.
- len=0 → no mem_we and no reads; done in cycle 2.
- In-place update with out_base=x_base, x=0xFFF0, result negative → word written is 0xFFFFxxxx (sign-extended), and a subsequent element reads correct unmodified x.
- reset asserted during the WR of element 5 → no write that cycle, outputs 0 next cycle; a restart completes normally.
